// File: rtl/game_flow_controller_pkg.sv
// Shared game-flow definitions: state encodings seen by the background and
// obstacle movers, BCD digit geometry and the default speed constants.
package game_flow_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DEAD = 2'b10
  } game_state_t;

  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_DIGITS  = 4;
  localparam int BCD_W       = BCD_DIGIT_W * BCD_DIGITS;

  localparam int DEF_START_SPEED       = 4;
  localparam int DEF_MAX_SPEED         = 30;
  localparam int DEF_SPEED_STEP_FRAMES = 300;
  localparam int DEF_SCORE_DIV         = 6;
  localparam int DEF_DEAD_HOLD         = 60;

endpackage

// File: rtl/game_flow_controller_bcd_counter4.sv
// Four-digit BCD incrementer with synchronous clear (wins over increment)
// and saturation at 9999.
module bcd_counter4
  import game_flow_controller_pkg::*;
(
  input  logic             FrameClk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] value
);

  logic [BCD_W-1:0] value_d;
  logic [BCD_W-1:0] incr;
  logic             carry;

  always_comb begin
    incr  = value;
    carry = 1'b1;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (carry) begin
        if (value[i*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd9) begin
          incr[i*BCD_DIGIT_W +: BCD_DIGIT_W] = '0;
        end else begin
          incr[i*BCD_DIGIT_W +: BCD_DIGIT_W] = value[i*BCD_DIGIT_W +: BCD_DIGIT_W] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  always_comb begin
    value_d = value;
    if (clr) begin
      value_d = '0;
    end else if (inc && value != 16'h9999) begin
      value_d = incr;
    end
  end

  always_ff @(posedge FrameClk or posedge rst) begin
    if (rst) value <= '0;
    else     value <= value_d;
  end

endmodule

// File: rtl/game_flow_controller.sv
// Per-frame IDLE/RUN/DEAD controller: scroll speed ramp, BCD score, high
// score and the new-game pulse for the scrolling stage.
module game_flow_controller
  import game_flow_controller_pkg::*;
#(
  parameter int START_SPEED       = DEF_START_SPEED,
  parameter int MAX_SPEED         = DEF_MAX_SPEED,
  parameter int SPEED_STEP_FRAMES = DEF_SPEED_STEP_FRAMES,
  parameter int SCORE_DIV         = DEF_SCORE_DIV,
  parameter int DEAD_HOLD         = DEF_DEAD_HOLD
) (
  input  logic              FrameClk,
  input  logic              rst,
  input  logic              jumpBtn,
  input  logic              collision,
  output logic [1:0]        gameState,
  output logic [7:0]        scrollSpeed,
  output logic [BCD_W-1:0]  scoreBCD,
  output logic [BCD_W-1:0]  highScoreBCD,
  output logic              newGame
);

  localparam int SPD_CNT_W = $clog2(SPEED_STEP_FRAMES + 1);
  localparam int SCR_CNT_W = $clog2(SCORE_DIV + 1);
  localparam int HOLD_W    = $clog2(DEAD_HOLD + 2);

  localparam logic [SPD_CNT_W-1:0] SPD_LAST  = SPD_CNT_W'(SPEED_STEP_FRAMES - 1);
  localparam logic [SCR_CNT_W-1:0] SCR_LAST  = SCR_CNT_W'(SCORE_DIV - 1);
  localparam logic [HOLD_W-1:0]    HOLD_MAX  = HOLD_W'(DEAD_HOLD);
  localparam logic [7:0]           SPD_START = 8'(START_SPEED);
  localparam logic [7:0]           SPD_MAX   = 8'(MAX_SPEED);

  game_state_t          state_q, state_d;
  logic                 btn_prev_q;
  logic [7:0]           speed_q, speed_d;
  logic [SPD_CNT_W-1:0] spd_cnt_q, spd_cnt_d;
  logic [SCR_CNT_W-1:0] scr_cnt_q, scr_cnt_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [BCD_W-1:0]     high_q, high_d;
  logic                 new_game_q, new_game_d;
  logic                 press, start, score_clr, score_inc;

  assign press = jumpBtn & ~btn_prev_q;

  always_comb begin
    state_d    = state_q;
    speed_d    = speed_q;
    spd_cnt_d  = spd_cnt_q;
    scr_cnt_d  = scr_cnt_q;
    hold_d     = hold_q;
    high_d     = high_q;
    new_game_d = 1'b0;
    score_clr  = 1'b0;
    score_inc  = 1'b0;
    start      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        speed_d = '0;
        start   = press;
      end
      ST_RUN: begin
        // Collision takes priority over any score/speed tick in the same frame.
        if (collision) begin
          state_d = ST_DEAD;
          speed_d = '0;
          hold_d  = '0;
          if (scoreBCD > high_q) high_d = scoreBCD;
        end else begin
          if (scr_cnt_q == SCR_LAST) begin
            scr_cnt_d = '0;
            score_inc = 1'b1;
          end else begin
            scr_cnt_d = scr_cnt_q + 1'b1;
          end
          if (spd_cnt_q == SPD_LAST) begin
            spd_cnt_d = '0;
            if (speed_q < SPD_MAX) speed_d = speed_q + 8'd1;
          end else begin
            spd_cnt_d = spd_cnt_q + 1'b1;
          end
        end
      end
      ST_DEAD: begin
        speed_d = '0;
        if (hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;
        start = press && (hold_q == HOLD_MAX);
      end
      default: state_d = ST_IDLE;
    endcase

    if (start) begin
      state_d    = ST_RUN;
      new_game_d = 1'b1;
      score_clr  = 1'b1;
      speed_d    = SPD_START;
      spd_cnt_d  = '0;
      scr_cnt_d  = '0;
    end
  end

  always_ff @(posedge FrameClk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      btn_prev_q <= 1'b0;
      speed_q    <= '0;
      spd_cnt_q  <= '0;
      scr_cnt_q  <= '0;
      hold_q     <= '0;
      high_q     <= '0;
      new_game_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      btn_prev_q <= jumpBtn;
      speed_q    <= speed_d;
      spd_cnt_q  <= spd_cnt_d;
      scr_cnt_q  <= scr_cnt_d;
      hold_q     <= hold_d;
      high_q     <= high_d;
      new_game_q <= new_game_d;
    end
  end

  bcd_counter4 u_score (
    .FrameClk (FrameClk),
    .rst      (rst),
    .clr      (score_clr),
    .inc      (score_inc),
    .value    (scoreBCD)
  );

  assign gameState    = state_q;
  assign scrollSpeed  = speed_q;
  assign highScoreBCD = high_q;
  assign newGame      = new_game_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed bench: instance A exercises press, ramp, collision and dead hold;
// instance B (one score per frame, zero hold) covers BCD carry and saturation.
module tb_game_flow_controller;

  logic        FrameClk = 1'b0;
  logic        rst = 1'b0;
  logic        jb_a = 1'b0, col_a = 1'b0, jb_b = 1'b0, col_b = 1'b0;
  logic [1:0]  gs_a, gs_b;
  logic [7:0]  spd_a, spd_b;
  logic [15:0] sc_a, sc_b, hi_a, hi_b;
  logic        ng_a, ng_b;

  int passed = 0;
  int total  = 0;
  int pulses;
  int exp_spd;

  always #5 FrameClk = ~FrameClk;

  game_flow_controller #(
    .START_SPEED(4), .MAX_SPEED(6), .SPEED_STEP_FRAMES(2),
    .SCORE_DIV(6), .DEAD_HOLD(60)
  ) dut_a (
    .FrameClk(FrameClk), .rst(rst), .jumpBtn(jb_a), .collision(col_a),
    .gameState(gs_a), .scrollSpeed(spd_a), .scoreBCD(sc_a),
    .highScoreBCD(hi_a), .newGame(ng_a)
  );

  game_flow_controller #(
    .START_SPEED(4), .MAX_SPEED(30), .SPEED_STEP_FRAMES(300),
    .SCORE_DIV(1), .DEAD_HOLD(0)
  ) dut_b (
    .FrameClk(FrameClk), .rst(rst), .jumpBtn(jb_b), .collision(col_b),
    .gameState(gs_b), .scrollSpeed(spd_b), .scoreBCD(sc_b),
    .highScoreBCD(hi_b), .newGame(ng_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge FrameClk);
    #1;
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    check("rst_state", 32'(gs_a), 32'h0);
    check("rst_speed", 32'(spd_a), 32'h0);
    check("rst_score", 32'(sc_a), 32'h0);
    check("rst_high", 32'(hi_a), 32'h0);
    check("rst_newgame", 32'(ng_a), 32'h0);
    #1 rst = 1'b0;

    // Held button: one press, one newGame pulse, speed ramps 4,5,5,6.
    jb_a = 1'b1;
    step(1);
    check("start_state", 32'(gs_a), 32'h1);
    check("start_newgame", 32'(ng_a), 32'h1);
    check("start_speed", 32'(spd_a), 32'd4);
    check("start_score", 32'(sc_a), 32'h0);
    pulses = 0;
    for (int j = 1; j <= 4; j++) begin
      step(1);
      pulses += int'(ng_a);
      exp_spd = (4 + j / 2 > 6) ? 6 : 4 + j / 2;
      check("ramp_speed", 32'(spd_a), 32'(exp_spd));
    end
    check("held_btn_pulses", 32'(pulses), 32'd0);
    check("held_btn_state", 32'(gs_a), 32'h1);
    jb_a = 1'b0;

    step(6);
    check("speed_sat_10", 32'(spd_a), 32'd6);
    step(50);
    check("score_60", 32'(sc_a), 32'h0010);

    // 65 RUN frames: a score tick is due on this frame, collision suppresses it.
    step(5);
    check("pre_col_score", 32'(sc_a), 32'h0010);
    col_a = 1'b1;
    step(1);
    col_a = 1'b0;
    check("col_state", 32'(gs_a), 32'h2);
    check("col_score", 32'(sc_a), 32'h0010);
    check("col_high", 32'(hi_a), 32'h0010);
    check("col_speed", 32'(spd_a), 32'd0);

    step(9);
    jb_a = 1'b1;
    step(1);
    jb_a = 1'b0;
    check("early_press_state", 32'(gs_a), 32'h2);
    check("early_press_newgame", 32'(ng_a), 32'h0);
    step(49);
    check("dead_frozen_score", 32'(sc_a), 32'h0010);
    step(1);
    jb_a = 1'b1;
    step(1);
    jb_a = 1'b0;
    check("restart_state", 32'(gs_a), 32'h1);
    check("restart_newgame", 32'(ng_a), 32'h1);
    check("restart_score", 32'(sc_a), 32'h0);
    check("restart_high", 32'(hi_a), 32'h0010);
    check("restart_speed", 32'(spd_a), 32'd4);

    // Asynchronous reset between edges.
    step(3);
    #2 rst = 1'b1;
    #1;
    check("async_state", 32'(gs_a), 32'h0);
    check("async_speed", 32'(spd_a), 32'h0);
    check("async_score", 32'(sc_a), 32'h0);
    check("async_high", 32'(hi_a), 32'h0);
    check("async_newgame", 32'(ng_a), 32'h0);
    #1 rst = 1'b0;

    // Instance B: one score per RUN frame.
    jb_b = 1'b1;
    step(1);
    jb_b = 1'b0;
    check("b_start_state", 32'(gs_b), 32'h1);
    check("b_start_newgame", 32'(ng_b), 32'h1);
    step(999);
    check("b_score_0999", 32'(sc_b), 32'h0999);
    step(1);
    check("b_score_1000", 32'(sc_b), 32'h1000);
    step(8998);
    check("b_score_9998", 32'(sc_b), 32'h9998);
    step(1);
    check("b_score_9999", 32'(sc_b), 32'h9999);
    step(5);
    check("b_score_hold", 32'(sc_b), 32'h9999);
    check("b_speed_max", 32'(spd_b), 32'd30);

    col_b = 1'b1;
    step(1);
    col_b = 1'b0;
    check("b_col_state", 32'(gs_b), 32'h2);
    check("b_col_high", 32'(hi_b), 32'h9999);
    jb_b = 1'b1;
    step(1);
    jb_b = 1'b0;
    check("b_hold0_state", 32'(gs_b), 32'h1);
    check("b_hold0_newgame", 32'(ng_b), 32'h1);
    check("b_hold0_score", 32'(sc_b), 32'h0);
    check("b_hold0_high", 32'(hi_b), 32'h9999);
    step(1);
    check("b_newgame_low", 32'(ng_b), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/game_flow_controller.md
Name: game_flow_controller

Overview:
- Frame-rate game-flow controller that feeds the background/ground scrolling stage.
- Runs the IDLE/RUN/DEAD state machine from the jump button and the collision flag.
- Drives the 2-bit game state, the per-frame scroll step, the BCD score, the BCD high score, and a one-frame new-game pulse.
- Clocked once per video frame; every count below is in frames.

Parameters:
- START_SPEED, 4, scroll step in pixels/frame at start of a run.
- MAX_SPEED, 30, saturation value of the scroll step.
- SPEED_STEP_FRAMES, 300, RUN frames between +1 speed increments.
- SCORE_DIV, 6, RUN frames per +1 score.
- DEAD_HOLD, 60, minimum DEAD frames before a restart press is accepted.

Ports:
- FrameClk  in  1  frame clock; one rising edge per video frame.
- rst  in  1  asynchronous, active-high reset.
- jumpBtn  in  1  jump/start button level, already synchronous to FrameClk.
- collision  in  1  dino/obstacle overlap, sampled once per frame.
- gameState  out  2  game state: 2'b00 IDLE, 2'b01 RUN, 2'b10 DEAD; 2'b11 is never driven.
- scrollSpeed  out  8  scroll step (dx) for the ground/obstacle movers.
- scoreBCD  out  16  current score, 4 BCD digits.
- highScoreBCD  out  16  best score since reset, 4 BCD digits.
- newGame  out  1  one-frame pulse on every entry to RUN.

Behaviour:
- Reset (asynchronous, active-high) values:
  - gameState=IDLE, scrollSpeed=0, scoreBCD=0, highScoreBCD=0, newGame=0.
  - All internal counters=0; btnPrev=0.
- Press definition: press = jumpBtn & ~btnPrev.
  - btnPrev <= jumpBtn every frame, in all states.
  - A held button produces exactly one press.
- IDLE:
  - scrollSpeed=0.
  - On press: next frame is RUN, newGame=1, scoreBCD=0, scrollSpeed=START_SPEED, speed and score counters cleared.
  - collision is ignored.
- RUN:
  - Score counter counts 0..SCORE_DIV-1. At the wrap, scoreBCD increments by 1 with decimal carry per digit.
  - scoreBCD saturates at 9999; it does not wrap.
  - Speed counter counts 0..SPEED_STEP_FRAMES-1. At the wrap, scrollSpeed = min(scrollSpeed+1, MAX_SPEED).
  - Presses are ignored (the jump is handled elsewhere).
- collision=1 in RUN:
  - Next frame is DEAD and scrollSpeed=0.
  - Any score or speed increment due in that same frame is suppressed; collision wins.
  - highScoreBCD <= scoreBCD if scoreBCD > highScoreBCD (4-digit BCD compares directly as unsigned).
  - Hold counter cleared.
- DEAD:
  - scoreBCD is frozen.
  - Hold counter increments and saturates at DEAD_HOLD.
  - A press while hold counter < DEAD_HOLD is ignored.
  - A press once hold counter == DEAD_HOLD behaves exactly as the IDLE press.
- newGame:
  - High exactly in the frame after the accepted press, i.e. the first RUN frame.
  - Low in all other frames.
  - Downstream movers use it to re-home positions.
- Latency: every output is registered, one frame after its cause.
- rst asserted mid-run: immediate return to reset values, and highScoreBCD is cleared.
- DEAD_HOLD=0: a press in the first DEAD frame restarts.

Decomposition:
- Shared package holds:
  - State encodings IDLE/RUN/DEAD, which are shared with the background and obstacle delegates.
  - BCD digit width.
  - Default speed constants.
- One natural sub-module, bcd_counter4: 4-digit BCD incrementer with increment enable, synchronous clear and saturation at 9999.
- The high-score compare is done inline.

Test Plan:
- Reset, then jumpBtn held high 5 frames → exactly one newGame pulse; gameState=01 from frame 2; scrollSpeed=4.
- SCORE_DIV=6, RUN 60 frames, no collision → scoreBCD=16'h0010.
- Speed ramp with SPEED_STEP_FRAMES=2, MAX_SPEED=6, START_SPEED=4:
  - after 4 RUN frames → scrollSpeed=6;
  - after 10 RUN frames → still 6.
- Collision on a frame where a score tick is due → gameState=10; scoreBCD unchanged; highScoreBCD=scoreBCD; scrollSpeed=0.
- DEAD_HOLD=60: press at DEAD frame 10 → stays DEAD; press at frame 61 → RUN, newGame=1, scoreBCD=0, highScoreBCD retained.
- Score preloaded near 9998, RUN continued → scoreBCD reaches 16'h9999 and holds.
- rst pulsed mid-RUN, asynchronous, between clock edges → outputs return to reset values immediately.
